// File: rtl/uart_rx_core.sv
// UART receiver: 2-flop rx sync, mid-bit sampling on baud ticks, LSB-first, optional parity, stop check.
// Latency: data_valid 1 clk after the stop-bit sample point; no backpressure, one pulse per frame.
module uart_rx_core #(
  parameter int OVERSAMPLING = 16,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud,
  input  logic                  rx,
  input  logic                  parEn,
  input  logic                  parType,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = $clog2(OVERSAMPLING);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] TC_HALF  = CW'(OVERSAMPLING / 2 - 1);
  localparam logic [CW-1:0] TC_FULL  = CW'(OVERSAMPLING - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                state, state_nxt;
  logic                  rx_meta, rx_s;
  logic [CW-1:0]         tick_cnt;
  logic [BW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_l, par_type_l, par_bit;
  logic                  sample;
  logic                  start_ok, data_shift, par_capture, stop_done;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  // The start bit is checked half a bit in; every later sample is a full bit apart.
  always_comb begin
    sample = baud && (tick_cnt == ((state == S_START) ? TC_HALF : TC_FULL));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ok    = 1'b0;
    data_shift  = 1'b0;
    par_capture = 1'b0;
    stop_done   = 1'b0;
    case (state)
      S_IDLE: if (!rx_s) state_nxt = S_START;
      S_START: begin
        if (sample) begin
          if (rx_s) begin
            state_nxt = S_IDLE;
          end else begin
            start_ok  = 1'b1;
            state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (sample) begin
          data_shift = 1'b1;
          if (bit_idx == LAST_BIT) state_nxt = par_en_l ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (sample) begin
          par_capture = 1'b1;
          state_nxt   = S_STOP;
        end
      end
      S_STOP: begin
        if (sample) begin
          stop_done = 1'b1;
          state_nxt = rx_s ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: if (rx_s) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Restart the bit timing on every state change; wrap explicitly so odd-sized counts work.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt <= '0;
    end else if (state_nxt != state) begin
      tick_cnt <= '0;
    end else if (sample) begin
      tick_cnt <= '0;
    end else if (baud) begin
      tick_cnt <= tick_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx    <= '0;
      shreg      <= '0;
      par_en_l   <= 1'b0;
      par_type_l <= 1'b0;
      par_bit    <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= stop_done;
      if (start_ok) begin
        par_en_l   <= parEn;
        par_type_l <= parType;
        bit_idx    <= '0;
      end
      if (data_shift) begin
        shreg   <= {rx_s, shreg[DATA_WIDTH-1:1]};
        bit_idx <= bit_idx + BW'(1);
      end
      if (par_capture) par_bit <= rx_s;
      if (stop_done) begin
        data_out   <= shreg;
        parity_err <= par_en_l & (par_bit != (^shreg ^ par_type_l));
        frame_err  <= ~rx_s;
      end
    end
  end

  assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core: baud every 4 clk, 64 clk per bit, frames driven LSB-first.
module tb_uart_rx_core;

  logic       clk, rst, baud, rx, parEn, parType;
  logic [7:0] data_out;
  logic       data_valid, parity_err, frame_err, busy;

  int compares = 0;
  int errors   = 0;
  int cyc      = 0;
  int dv_count = 0;
  int last_time = 0, prev_time = 0;
  logic [7:0] last_data = 8'h00, prev_data = 8'h00;

  uart_rx_core #(.OVERSAMPLING(16), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .baud(baud), .rx(rx), .parEn(parEn), .parType(parType),
    .data_out(data_out), .data_valid(data_valid), .parity_err(parity_err),
    .frame_err(frame_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    baud = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud = 1'b1;
      @(negedge clk);
      baud = 1'b0;
    end
  end

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (data_valid) begin
      dv_count++;
      prev_data = last_data;
      prev_time = last_time;
      last_data = data_out;
      last_time = cyc;
    end
  end

  task automatic send_bit(input logic b);
    rx = b;
    repeat (64) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic with_par, input logic pbit,
                            input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (with_par) send_bit(pbit);
    send_bit(stop);
  endtask

  task automatic test_reset();
    rx = 1'b1; parEn = 1'b0; parType = 1'b0; rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    compares++; if (data_out !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_out); end
    compares++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", data_valid); end
    compares++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr: got %b want 0", parity_err); end
    compares++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err); end
    compares++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_no_parity();
    int n0;
    n0 = dv_count;
    parEn = 1'b0;
    send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    compares++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL np_count: got %0d want 1", dv_count - n0); end
    compares++; if (data_out !== 8'hA5) begin errors++; $display("FAIL np_data: got %h want a5", data_out); end
    compares++; if (parity_err !== 1'b0) begin errors++; $display("FAIL np_perr: got %b want 0", parity_err); end
    compares++; if (frame_err !== 1'b0) begin errors++; $display("FAIL np_ferr: got %b want 0", frame_err); end
    compares++; if (busy !== 1'b0) begin errors++; $display("FAIL np_busy: got %b want 0", busy); end
  endtask

  task automatic test_parity_even();
    int n0;
    n0 = dv_count;
    parEn = 1'b1; parType = 1'b0;
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    compares++; if (parity_err !== 1'b0) begin errors++; $display("FAIL even_ok_perr: got %b want 0", parity_err); end
    compares++; if (data_out !== 8'h3C) begin errors++; $display("FAIL even_ok_data: got %h want 3c", data_out); end
    send_frame(8'h3C, 1'b1, 1'b1, 1'b1);
    repeat (32) @(negedge clk);
    compares++; if (parity_err !== 1'b1) begin errors++; $display("FAIL even_bad_perr: got %b want 1", parity_err); end
    compares++; if (data_out !== 8'h3C) begin errors++; $display("FAIL even_bad_data: got %h want 3c", data_out); end
    compares++; if (dv_count - n0 !== 2) begin errors++; $display("FAIL even_count: got %0d want 2", dv_count - n0); end
  endtask

  task automatic test_parity_odd();
    parEn = 1'b1; parType = 1'b1;
    send_frame(8'h01, 1'b1, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    compares++; if (parity_err !== 1'b0) begin errors++; $display("FAIL odd_ok_perr: got %b want 0", parity_err); end
    compares++; if (data_out !== 8'h01) begin errors++; $display("FAIL odd_ok_data: got %h want 01", data_out); end
    send_frame(8'h01, 1'b1, 1'b1, 1'b1);
    repeat (32) @(negedge clk);
    compares++; if (parity_err !== 1'b1) begin errors++; $display("FAIL odd_bad_perr: got %b want 1", parity_err); end
  endtask

  task automatic test_glitch();
    int n0;
    n0 = dv_count;
    parEn = 1'b0; parType = 1'b0;
    rx = 1'b0;
    repeat (8) @(negedge clk);
    compares++; if (busy !== 1'b1) begin errors++; $display("FAIL glitch_busy_in: got %b want 1", busy); end
    repeat (8) @(negedge clk);
    rx = 1'b1;
    repeat (64) @(negedge clk);
    compares++; if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy_out: got %b want 0", busy); end
    compares++; if (dv_count - n0 !== 0) begin errors++; $display("FAIL glitch_count: got %0d want 0", dv_count - n0); end
  endtask

  task automatic test_break();
    int n0;
    n0 = dv_count;
    send_frame(8'h55, 1'b0, 1'b0, 1'b0);
    repeat (192) @(negedge clk);
    compares++; if (dv_count - n0 !== 1) begin errors++; $display("FAIL brk_count: got %0d want 1", dv_count - n0); end
    compares++; if (frame_err !== 1'b1) begin errors++; $display("FAIL brk_ferr: got %b want 1", frame_err); end
    compares++; if (data_out !== 8'h55) begin errors++; $display("FAIL brk_data: got %h want 55", data_out); end
    compares++; if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy_low: got %b want 1", busy); end
    rx = 1'b1;
    repeat (16) @(negedge clk);
    compares++; if (busy !== 1'b0) begin errors++; $display("FAIL brk_busy_high: got %b want 0", busy); end
    send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    compares++; if (dv_count - n0 !== 2) begin errors++; $display("FAIL brk_next_count: got %0d want 2", dv_count - n0); end
    compares++; if (data_out !== 8'h0F) begin errors++; $display("FAIL brk_next_data: got %h want 0f", data_out); end
    compares++; if (frame_err !== 1'b0) begin errors++; $display("FAIL brk_next_ferr: got %b want 0", frame_err); end
  endtask

  task automatic test_reset_mid_frame();
    int n0;
    logic [7:0] d;
    n0 = dv_count;
    d = 8'h81;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(d[i]);
    rx = d[4];
    repeat (32) @(negedge clk);
    rst = 1'b0;
    #1;
    compares++; if (data_out !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h want 00", data_out); end
    compares++; if (data_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b want 0", data_valid); end
    compares++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", busy); end
    compares++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b want 0", frame_err); end
    compares++; if (parity_err !== 1'b0) begin errors++; $display("FAIL rstmid_perr: got %b want 0", parity_err); end
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (64) @(negedge clk);
    compares++; if (dv_count - n0 !== 0) begin errors++; $display("FAIL rstmid_count: got %0d want 0", dv_count - n0); end
  endtask

  task automatic test_back_to_back();
    int n0;
    n0 = dv_count;
    send_frame(8'h00, 1'b0, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b0, 1'b1);
    repeat (32) @(negedge clk);
    compares++; if (dv_count - n0 !== 2) begin errors++; $display("FAIL b2b_count: got %0d want 2", dv_count - n0); end
    compares++; if (prev_data !== 8'h00) begin errors++; $display("FAIL b2b_first: got %h want 00", prev_data); end
    compares++; if (last_data !== 8'hFF) begin errors++; $display("FAIL b2b_second: got %h want ff", last_data); end
    compares++; if (last_time - prev_time !== 640) begin errors++; $display("FAIL b2b_spacing: got %0d want 640", last_time - prev_time); end
    compares++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_ferr: got %b want 0", frame_err); end
  endtask

  initial begin
    test_reset();
    test_no_parity();
    test_parity_even();
    test_parity_odd();
    test_glitch();
    test_break();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
